// File: rtl/mem_copy_dma_pkg.sv
// Shared types and default widths for the mem_copy_dma block copier.
package mem_copy_dma_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Base address / word index bookkeeping for mem_copy_dma.
module mem_copy_addr_gen
    import mem_copy_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] dst_cur,
    output logic [ADDR_W-1:0] src_next,
    output logic              last
);

    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] src_cur;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_base <= '0;
            dst_base <= '0;
            len_q    <= '0;
            idx      <= '0;
        end else if (load) begin
            src_base <= src_in;
            dst_base <= dst_in;
            len_q    <= len_in;
            idx      <= '0;
        end else if (advance) begin
            idx <= idx + LEN_W'(1);
        end
    end

    // Arithmetic is modulo 2^ADDR_W; wrap is intentional.
    assign offset   = ADDR_W'(idx) * ADDR_W'(STRIDE);
    assign src_cur  = src_base + offset;
    assign dst_cur  = dst_base + offset;
    assign src_next = src_cur + ADDR_W'(STRIDE);
    assign last     = (idx == len_q - LEN_W'(1));

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word memory block copier (read cycle then write cycle per word).
// Optional checksum output enabled by MEM_COPY_DMA_CHECKSUM_EN.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_q;
    logic              accept;
    logic              load;
    logic              advance;
    logic [ADDR_W-1:0] dst_cur;
    logic [ADDR_W-1:0] src_next;
    logic              last;

    assign accept  = (state == IDLE) && start;
    assign load    = accept && (len != '0);
    assign advance = (state == WR) && !last;

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .src_in   (src_addr),
        .dst_in   (dst_addr),
        .len_in   (len),
        .dst_cur  (dst_cur),
        .src_next (src_next),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            buf_q  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state  <= RD;
                            busy   <= 1'b1;
                            rd_q   <= 1'b1;
                            addr_q <= src_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    buf_q  <= mem_rdata;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    addr_q <= dst_cur;
                    state  <= WR;
                end
                WR: begin
                    wr_q <= 1'b0;
                    if (last) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        addr_q <= '0;
                    end else begin
                        state  <= RD;
                        rd_q   <= 1'b1;
                        addr_q <= src_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes are released while reset is held so an in-flight access is dropped.
    assign mem_read  = rd_q && !reset;
    assign mem_write = wr_q && !reset;
    assign mem_addr  = reset ? '0 : addr_q;
    assign mem_wdata = buf_q;

`ifdef MEM_COPY_DMA_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            checksum <= '0;
        end else if (state == WR) begin
            checksum <= checksum + buf_q;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed, table-driven bench for mem_copy_dma with a 256-word memory model.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    mem_copy_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    logic [31:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[7:0]] <= mem_wdata;
        else if (tb_we)
            mem[tb_wa] <= tb_wd;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    int          r_busy, r_done_cyc, r_done_cnt, r_acc, r_both, r_badaddr, r_ntrace;
    logic [31:0] trace [64];
    logic [31:0] r_cs;

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n);
        r_busy = 0; r_done_cyc = -1; r_done_cnt = 0; r_acc = 0; r_both = 0;
        r_badaddr = 0; r_ntrace = 0; r_cs = '0;
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            if (busy) r_busy++;
            if (mem_read && mem_write) r_both++;
            if (mem_read || mem_write) begin
                r_acc++;
                if (r_ntrace < 64) begin
                    trace[r_ntrace] = mem_addr;
                    r_ntrace++;
                end
            end else if (mem_addr != '0) begin
                r_badaddr++;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = cyc;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
                    r_cs = checksum;
`endif
                end
            end
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 2) break;
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [8:0]  len;
        int          exp_busy;
        int          exp_done;
    } copy_vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } mem_vec_t;

    copy_vec_t cv [3];
    mem_vec_t  mv [6];
    logic [31:0] exp_trace [8];
    int          cyc_seen;

    initial begin
        cv[0] = '{src: 32'd10, dst: 32'd40, len: 9'd4, exp_busy: 8, exp_done: 9};
        cv[1] = '{src: 32'd20, dst: 32'd60, len: 9'd1, exp_busy: 2, exp_done: 3};
        cv[2] = '{src: 32'd30, dst: 32'd70, len: 9'd0, exp_busy: 0, exp_done: 1};

        mv[0] = '{addr: 8'd40, data: 32'hA};
        mv[1] = '{addr: 8'd41, data: 32'hB};
        mv[2] = '{addr: 8'd42, data: 32'hC};
        mv[3] = '{addr: 8'd43, data: 32'hD};
        mv[4] = '{addr: 8'd60, data: 32'h55};
        mv[5] = '{addr: 8'd70, data: 32'h0};

        exp_trace = '{32'd254, 32'd100, 32'd255, 32'd101, 32'd256, 32'd102, 32'd257, 32'd103};

        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_write", mem_write, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check("reset_checksum", checksum, 0);
`endif

        @(posedge clk); #1;
        tb_we = 1'b1;
        for (int a = 0; a < 256; a++) begin
            tb_wa = 8'(a); tb_wd = '0;
            @(posedge clk); #1;
        end
        tb_we = 1'b0;

        poke(8'd10, 32'hA); poke(8'd11, 32'hB); poke(8'd12, 32'hC); poke(8'd13, 32'hD);
        poke(8'd20, 32'h55); poke(8'd30, 32'h77);

        for (int k = 0; k < 3; k++) begin
            run_copy(cv[k].src, cv[k].dst, cv[k].len);
            check($sformatf("v%0d_busy_cycles", k), r_busy, cv[k].exp_busy);
            check($sformatf("v%0d_done_cycle", k), r_done_cyc, cv[k].exp_done);
            check($sformatf("v%0d_done_count", k), r_done_cnt, 1);
            check($sformatf("v%0d_accesses", k), r_acc, 2 * int'(cv[k].len));
            check($sformatf("v%0d_rd_wr_overlap", k), r_both, 0);
            check($sformatf("v%0d_idle_addr", k), r_badaddr, 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
            if (cv[k].len == 9'd0) check($sformatf("v%0d_checksum", k), r_cs, 0);
`endif
        end
        for (int k = 0; k < 6; k++)
            check($sformatf("mem_%0d", mv[k].addr), mem[mv[k].addr], mv[k].data);

        // Wrap across the 8-bit decode boundary
        poke(8'd254, 32'd1); poke(8'd255, 32'd2); poke(8'd0, 32'd3); poke(8'd1, 32'd4);
        run_copy(32'd254, 32'd100, 9'd4);
        check("wrap_trace_len", r_ntrace, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("wrap_addr_%0d", k), trace[k], exp_trace[k]);
        for (int k = 0; k < 4; k++)
            check($sformatf("wrap_mem_%0d", 100 + k), mem[100 + k], k + 1);

        // Forward overlap smears the first word
        poke(8'd0, 32'd5); poke(8'd1, 32'd6); poke(8'd2, 32'd7); poke(8'd3, 32'd8);
        run_copy(32'd0, 32'd1, 9'd3);
        check("ovl_mem_0", mem[0], 5);
        check("ovl_mem_1", mem[1], 5);
        check("ovl_mem_2", mem[2], 5);
        check("ovl_mem_3", mem[3], 5);

        // Reset during the write cycle of word 2 of an 8-word copy
        for (int k = 0; k < 8; k++) poke(8'(8'h80 + k), 32'h100 + k);
        @(posedge clk); #1;
        start = 1'b1; src_addr = 32'h80; dst_addr = 32'hC0; len = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        cyc_seen = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (done) cyc_seen++;
        end
        check("rst_wr2_mem_write", mem_write, 1);
        check("rst_wr2_mem_addr", mem_addr, 32'hC2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (done) cyc_seen++;
            if (cyc == 0) begin
                check("rst_idle_busy", busy, 0);
                check("rst_idle_rd", mem_read, 0);
                check("rst_idle_wr", mem_write, 0);
            end
        end
        check("rst_no_done", cyc_seen, 0);
        check("rst_mem_c0", mem[8'hC0], 32'h100);
        check("rst_mem_c1", mem[8'hC1], 32'h101);
        check("rst_mem_c2", mem[8'hC2], 32'h0);
        check("rst_mem_c3", mem[8'hC3], 32'h0);
        run_copy(32'h80, 32'hC8, 9'd2);
        check("rst_restart_done", r_done_cyc, 5);
        check("rst_restart_c8", mem[8'hC8], 32'h100);
        check("rst_restart_c9", mem[8'hC9], 32'h101);

`ifdef MEM_COPY_DMA_CHECKSUM_EN
        poke(8'h50, 32'hFFFF_FFFF); poke(8'h51, 32'h0000_0002);
        run_copy(32'h50, 32'h58, 9'd2);
        check("cs_at_done", r_cs, 32'h1);
        check("cs_stable", checksum, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
